// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the single-precision FP multiply sequencer.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL_WAIT,
    NORM_RND,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } rnd_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] MAXNORM = 31'h7F7F_FFFF;
  localparam logic [30:0] INF     = 31'h7F80_0000;

  localparam int FLG_TIMEOUT   = 4;
  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

endpackage

// File: rtl/fp_mult_ctrl_if.sv
// Operand, shared-multiplier and result handshakes of the FP multiply sequencer.
interface fp_mult_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  rnd;
  logic        mul_req;
  logic [23:0] mul_a;
  logic [23:0] mul_b;
  logic        mul_ack;
  logic [47:0] mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic [4:0]  flags;

  modport slave (
    input  in_valid, a, b, rnd, mul_ack, mul_p, out_ready,
    output in_ready, mul_req, mul_a, mul_b, out_valid, z, flags
  );

  modport master (
    output in_valid, a, b, rnd, mul_ack, mul_p, out_ready,
    input  in_ready, mul_req, mul_a, mul_b, out_valid, z, flags
  );

endinterface

// File: rtl/fp_round_pack.sv
// Combinational normalize, round, range-check and pack of a 48-bit mantissa product.
module fp_round_pack
  import fp_mult_pkg::*;
(
  input  logic [47:0]        p,
  input  logic signed [9:0]  exp_in,
  input  logic               sign,
  input  rnd_t               rnd,
  output logic [31:0]        z,
  output logic [4:0]         flags
);

  function automatic logic round_inc(input rnd_t mode, input logic g, input logic s,
                                     input logic lsb, input logic sgn);
    logic inc;
    inc = 1'b0;
    case (mode)
      RND_RNE: inc = g & (s | lsb);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = (g | s) & ~sgn;
      RND_RDN: inc = (g | s) & sgn;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

  function automatic logic [31:0] ovf_result(input rnd_t mode, input logic sgn);
    logic [31:0] r;
    r = {sgn, INF};
    case (mode)
      RND_RNE: r = {sgn, INF};
      RND_RTZ: r = {sgn, MAXNORM};
      RND_RUP: r = sgn ? {1'b1, MAXNORM} : {1'b0, INF};
      RND_RDN: r = sgn ? {1'b1, INF} : {1'b0, MAXNORM};
      default: r = {sgn, INF};
    endcase
    return r;
  endfunction

  logic               norm;
  logic [22:0]        mant;
  logic               g;
  logic               s;
  logic               inc;
  logic               carry;
  logic [22:0]        mant_r;
  logic signed [9:0]  exp_n;
  logic signed [9:0]  exp_r;

  // A product of two [1,2) mantissas lies in [1,4); bit 47 says which half.
  assign norm  = p[47];
  assign mant  = norm ? p[46:24] : p[45:23];
  assign g     = norm ? p[23] : p[22];
  assign s     = norm ? |p[22:0] : |p[21:0];
  assign exp_n = exp_in + (norm ? 10'sd1 : 10'sd0);
  assign inc   = round_inc(rnd, g, s, mant[0], sign);
  assign {carry, mant_r} = {1'b0, mant} + {23'b0, inc};
  assign exp_r = exp_n + (carry ? 10'sd1 : 10'sd0);

  always_comb begin
    z     = {sign, exp_r[7:0], mant_r};
    flags = '0;
    flags[FLG_INEXACT] = g | s;
    if (exp_r >= 10'sd255) begin
      z                    = ovf_result(rnd, sign);
      flags[FLG_OVERFLOW]  = 1'b1;
      flags[FLG_INEXACT]   = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      z                    = {sign, 31'b0};
      flags[FLG_UNDERFLOW] = 1'b1;
      flags[FLG_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult_ctrl.sv
// Single-precision FP multiply sequencer: screens specials, drives a shared
// variable-latency mantissa multiplier, then rounds and returns the result.
module fp_mult_ctrl
  import fp_mult_pkg::*;
#(
  parameter int EXP_BIAS = 127,
  parameter int TIMEOUT  = 15
) (
  input logic          clk,
  input logic          rst_n,
  fp_mult_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic signed [9:0] BIAS10 = 10'(EXP_BIAS);

  state_t state, state_nxt;

  logic [31:0]       a_q, b_q;
  rnd_t              rnd_q;
  logic [47:0]       p_q;
  logic signed [9:0] exp_q;
  logic [TW-1:0]     tcnt;
  logic [TW-1:0]     tcnt_nxt;
  logic              timeout_hit;
  logic [23:0]       mul_a_q, mul_b_q;
  logic [31:0]       z_q;
  logic [4:0]        flags_q;

  logic              sign;
  logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic              special;
  logic [31:0]       spec_z;
  logic [4:0]        spec_f;
  logic signed [9:0] exp_calc;
  logic [31:0]       rp_z;
  logic [4:0]        rp_flags;

  // Operand screening; denormal inputs count as zero.
  assign sign   = a_q[31] ^ b_q[31];
  assign zero_a = (a_q[30:23] == 8'h00);
  assign zero_b = (b_q[30:23] == 8'h00);
  assign inf_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
  assign inf_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
  assign nan_a  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
  assign nan_b  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
  assign special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;

  always_comb begin
    spec_z = {sign, 31'b0};
    spec_f = '0;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      spec_z              = QNAN;
      spec_f[FLG_INVALID] = 1'b1;
    end else if (inf_a || inf_b) begin
      spec_z = {sign, INF};
    end
  end

  assign exp_calc    = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - BIAS10;
  assign tcnt_nxt    = tcnt + 1'b1;
  assign timeout_hit = (tcnt_nxt == TW'(TIMEOUT));

  fp_round_pack u_round_pack (
    .p      (p_q),
    .exp_in (exp_q),
    .sign   (sign),
    .rnd    (rnd_q),
    .z      (rp_z),
    .flags  (rp_flags)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.in_valid) state_nxt = CHECK;
      CHECK:    state_nxt = special ? HOLD : MUL_WAIT;
      MUL_WAIT: begin
        if (bus.mul_ack)      state_nxt = NORM_RND;
        else if (timeout_hit) state_nxt = HOLD;
      end
      NORM_RND: state_nxt = HOLD;
      HOLD:     if (bus.out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Control and visible outputs: cleared by reset so an abort leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tcnt    <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      z_q     <= '0;
      flags_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        CHECK: begin
          if (special) begin
            z_q     <= spec_z;
            flags_q <= spec_f;
          end else begin
            mul_a_q <= {1'b1, a_q[22:0]};
            mul_b_q <= {1'b1, b_q[22:0]};
            tcnt    <= '0;
          end
        end
        MUL_WAIT: begin
          if (!bus.mul_ack) begin
            tcnt <= tcnt_nxt;
            if (timeout_hit) begin
              z_q     <= QNAN;
              flags_q <= 5'(1 << FLG_TIMEOUT);
            end
          end
        end
        NORM_RND: begin
          z_q     <= rp_z;
          flags_q <= rp_flags;
        end
        default: ;
      endcase
    end
  end

  // Operand, exponent and product registers only load on their own state.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      rnd_q <= rnd_t'(bus.rnd);
    end
    if (state == CHECK)                 exp_q <= exp_calc;
    if (state == MUL_WAIT && bus.mul_ack) p_q <= bus.mul_p;
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.mul_req   = (state == MUL_WAIT);
  assign bus.out_valid = (state == HOLD);
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.z         = z_q;
  assign bus.flags     = flags_q;

endmodule
